axi_wr_arbiter_rr: RTL and testbench

Parametrised round-robin write-channel arbiter for the AXI interconnect. It selects one of NUM_MASTERS slave-port write requests and holds the grant for the whole write transaction: AW accept, W burst through WLAST, and optionally the B response. An explicit idle state replaces the high-impedance "no owner" encoding. The interconnect write-path muxes are steered from its registered grant.

---
 rtl/axi_arb_pkg.sv | 18 +
 rtl/axi_rr_picker.sv | 42 ++++
 rtl/axi_wr_arbiter_rr.sv | 130 +++++++++++++
 tb/tb_axi_wr_arbiter_rr.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write/read channel arbiters.
//   arb_state_t : arbiter FSM states (IDLE, ADDR, DATA, RESP)
//   idx_width() : index width for N requesters, never below 1 bit
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   // $clog2 returns 0 for a single requester; a zero-width index is not legal
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin select: first set request searching upward from
// (last_idx_i + 1) mod NUM_MASTERS, wrapping.
//   req_i      : request vector
//   last_idx_i : index of the previous winner
//   pick_o     : one-hot winner (all-zero when no request)
//   idx_o      : binary winner index (0 when no request)
//   any_req_o  : at least one request set
module axi_rr_picker
   import axi_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = 2,
   localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]       last_idx_i,
   output logic [NUM_MASTERS-1:0] pick_o,
   output logic [IDX_W-1:0]       idx_o,
   output logic                   any_req_o
);

   logic        found;
   int unsigned cand;

   // Offsets 1..N visit every port once, ending at last_idx_i itself
   always_comb begin
      pick_o = '0;
      idx_o  = '0;
      found  = 1'b0;
      cand   = 0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         cand = (32'(last_idx_i) + i) % NUM_MASTERS;
         if (!found && req_i[IDX_W'(cand)]) begin
            found                = 1'b1;
            pick_o[IDX_W'(cand)] = 1'b1;
            idx_o                = IDX_W'(cand);
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/axi_wr_arbiter_rr.sv
// Round-robin AXI write-channel arbiter. Holds the grant for a whole write
// transaction (AW accept, W burst through WLAST, optionally the B response).
// Build option: define AXI_ARB_WAIT_BRESP_EN to hold the grant until the
// B handshake; otherwise the transaction ends at the last W/AW handshake.
//   clk, reset   : clock, asynchronous active-high reset
//   s_awvalid    : AWVALID per requesting port
//   m_awready    : AWREADY from downstream
//   m_wvalid/m_wready/m_wlast : muxed W channel handshake
//   m_bvalid/m_bready         : B channel handshake
//   grant        : one-hot owner, zero when idle
//   grant_idx    : binary owner index, holds last owner when idle
//   grant_valid  : channel currently owned
//   aw_done      : owner's AW handshake already completed
module axi_wr_arbiter_rr
   import axi_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = 2,
   localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] s_awvalid,
   input  logic                   m_awready,
   input  logic                   m_wvalid,
   input  logic                   m_wready,
   input  logic                   m_wlast,
   input  logic                   m_bvalid,
   input  logic                   m_bready,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [IDX_W-1:0]       grant_idx,
   output logic                   grant_valid,
   output logic                   aw_done
);

   arb_state_t             state_q;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [IDX_W-1:0]       grant_idx_q;
   logic [IDX_W-1:0]       last_idx_q;
   logic                   grant_valid_q;
   logic                   aw_done_q;
   logic                   wlast_seen_q;

   logic [NUM_MASTERS-1:0] pick;
   logic [IDX_W-1:0]       pick_idx;
   logic                   any_req;
   logic                   aw_fire;
   logic                   wlast_fire;
   logic                   txn_end;

   axi_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_picker (
      .req_i      (s_awvalid),
      .last_idx_i (last_idx_q),
      .pick_o     (pick),
      .idx_o      (pick_idx),
      .any_req_o  (any_req)
   );

   assign aw_fire    = s_awvalid[grant_idx_q] & m_awready;
   assign wlast_fire = m_wvalid & m_wready & m_wlast;

   // State entered once both AW and the last W beat are done
`ifdef AXI_ARB_WAIT_BRESP_EN
   localparam arb_state_t POST_W = RESP;
   logic b_fire;
   assign b_fire  = m_bvalid & m_bready;
   assign txn_end = (state_q == RESP) && b_fire;
`else
   localparam arb_state_t POST_W = IDLE;
   logic unused_b;
   assign unused_b = m_bvalid & m_bready;
   assign txn_end  = ((state_q == ADDR) && aw_fire && (wlast_seen_q || wlast_fire))
                  || ((state_q == DATA) && wlast_fire);
`endif

   // Arbitration FSM; txn_end overrides the case to clear all ownership state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         last_idx_q    <= IDX_W'(NUM_MASTERS - 1);
         grant_valid_q <= 1'b0;
         aw_done_q     <= 1'b0;
         wlast_seen_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q       <= pick;
                  grant_idx_q   <= pick_idx;
                  last_idx_q    <= pick_idx;
                  grant_valid_q <= 1'b1;
                  state_q       <= ADDR;
               end
            end
            ADDR: begin
               if (wlast_fire) wlast_seen_q <= 1'b1;
               if (aw_fire) begin
                  aw_done_q <= 1'b1;
                  state_q   <= (wlast_seen_q || wlast_fire) ? POST_W : DATA;
               end
            end
            DATA: begin
               if (wlast_fire) state_q <= POST_W;
            end
`ifdef AXI_ARB_WAIT_BRESP_EN
            RESP: begin
               state_q <= RESP;
            end
`endif
            default: state_q <= IDLE;
         endcase
         if (txn_end) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            aw_done_q     <= 1'b0;
            wlast_seen_q  <= 1'b0;
         end
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign aw_done     = aw_done_q;

endmodule

// File: tb/tb_axi_wr_arbiter_rr.sv
// Directed bench for axi_wr_arbiter_rr with NUM_MASTERS=4. Expected winners
// are queued when requests are driven and popped when a grant appears.
module tb_axi_wr_arbiter_rr;

   localparam int unsigned NM = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NM-1:0] s_awvalid = '0;
   logic          m_awready = 1'b0;
   logic          m_wvalid = 1'b0;
   logic          m_wready = 1'b0;
   logic          m_wlast = 1'b0;
   logic          m_bvalid = 1'b0;
   logic          m_bready = 1'b0;
   logic [NM-1:0] grant;
   logic [1:0]    grant_idx;
   logic          grant_valid;
   logic          aw_done;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int owner;

   axi_wr_arbiter_rr #(.NUM_MASTERS(NM)) dut (
      .clk         (clk),
      .reset       (reset),
      .s_awvalid   (s_awvalid),
      .m_awready   (m_awready),
      .m_wvalid    (m_wvalid),
      .m_wready    (m_wready),
      .m_wlast     (m_wlast),
      .m_bvalid    (m_bvalid),
      .m_bready    (m_bready),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .aw_done     (aw_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NM-1:0] onehot(input int idx);
      logic [NM-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Pop the expected winner and compare against the current grant
   task automatic check_grant(input string tag, output int idx);
      idx = 0;
      check({tag, "_valid"}, 32'(grant_valid), 32'd1);
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (exp_q.size() > 0) begin
         idx = exp_q.pop_front();
         check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
         check({tag, "_onehot"}, 32'(grant), 32'(onehot(idx)));
      end
   endtask

   task automatic aw_phase();
      m_awready = 1'b1;
      tick();
      m_awready = 1'b0;
      check("aw_done_set", 32'(aw_done), 32'd1);
   endtask

   // Called right after the final W (or AW) handshake cycle
   task automatic end_phase(input int idx);
`ifdef AXI_ARB_WAIT_BRESP_EN
      check("resp_hold", 32'(grant), 32'(onehot(idx)));
      m_bvalid = 1'b1;
      m_bready = 1'b1;
      tick();
      m_bvalid = 1'b0;
      m_bready = 1'b0;
`endif
      check("idle_valid", 32'(grant_valid), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_aw_done", 32'(aw_done), 32'd0);
      check("idle_idx_hold", 32'(grant_idx), 32'(idx));
   endtask

   task automatic w_phase(input int beats, input int idx);
      for (int b = 0; b < beats; b++) begin
         m_wvalid = 1'b1;
         m_wready = 1'b1;
         m_wlast  = (b == beats - 1);
         tick();
         m_wvalid = 1'b0;
         m_wready = 1'b0;
         m_wlast  = 1'b0;
         if (b < beats - 1) check("data_hold", 32'(grant), 32'(onehot(idx)));
      end
      end_phase(idx);
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_idx", 32'(grant_idx), 32'd0);
      check("rst_valid", 32'(grant_valid), 32'd0);
      check("rst_aw_done", 32'(aw_done), 32'd0);
      reset = 1'b0;

      // Single master, 4-beat burst
      s_awvalid = 4'b0001;
      exp_q.push_back(0);
      tick();
      check_grant("t1", owner);
      check("t1_aw_done0", 32'(aw_done), 32'd0);
      aw_phase();
      s_awvalid = 4'b0000;
      w_phase(4, 0);
      tick();
      check("t1_stay_idle", 32'(grant_valid), 32'd0);

      // All requesting, 1-beat bursts from a fresh reset: 0,1,2,3,0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      s_awvalid = 4'b1111;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(0);
      tick();
      for (int k = 0; k < 5; k++) begin
         check_grant("rr", owner);
         aw_phase();
         w_phase(1, owner);
         if (k == 4) s_awvalid = 4'b0000;
         else tick();
      end

      // Owner 2 holds while others request; then 3 is searched before 1
      s_awvalid = 4'b0100;
      exp_q.push_back(2);
      tick();
      check_grant("own2", owner);
      aw_phase();
      s_awvalid = 4'b0110;
      tick();
      check("own2_hold_m1", 32'(grant), 32'b0100);
      s_awvalid = 4'b1010;
      w_phase(3, 2);
      exp_q.push_back(3);
      tick();
      check_grant("after2", owner);
      aw_phase();
      s_awvalid = 4'b0010;
      w_phase(2, 3);
      exp_q.push_back(1);
      tick();
      check_grant("after3", owner);
      aw_phase();
      s_awvalid = 4'b0000;
      w_phase(1, 1);

      // W before AW: WLAST in ADDR, then AW skips DATA
      s_awvalid = 4'b0001;
      exp_q.push_back(0);
      tick();
      check_grant("wfirst", owner);
      m_wvalid = 1'b1;
      m_wready = 1'b1;
      m_wlast  = 1'b1;
      tick();
      m_wvalid = 1'b0;
      m_wready = 1'b0;
      m_wlast  = 1'b0;
      check("wfirst_aw_done0", 32'(aw_done), 32'd0);
      check("wfirst_in_addr", 32'(grant_valid), 32'd1);
      m_awready = 1'b1;
      tick();
      m_awready = 1'b0;
      s_awvalid = 4'b0000;
`ifdef AXI_ARB_WAIT_BRESP_EN
      check("wfirst_aw_done1", 32'(aw_done), 32'd1);
`endif
      end_phase(0);

      // Same-cycle AW and WLAST handshakes
      s_awvalid = 4'b0010;
      exp_q.push_back(1);
      tick();
      check_grant("same", owner);
      m_awready = 1'b1;
      m_wvalid  = 1'b1;
      m_wready  = 1'b1;
      m_wlast   = 1'b1;
      tick();
      m_awready = 1'b0;
      m_wvalid  = 1'b0;
      m_wready  = 1'b0;
      m_wlast   = 1'b0;
      s_awvalid = 4'b0000;
`ifdef AXI_ARB_WAIT_BRESP_EN
      check("same_aw_done1", 32'(aw_done), 32'd1);
`endif
      end_phase(1);

      // Reset pulse mid-DATA
      s_awvalid = 4'b0100;
      exp_q.push_back(2);
      tick();
      check_grant("rstmid", owner);
      aw_phase();
      m_wvalid = 1'b1;
      m_wready = 1'b1;
      tick();
      m_wvalid = 1'b0;
      m_wready = 1'b0;
      check("rstmid_data", 32'(grant), 32'b0100);
      reset = 1'b1;
      s_awvalid = 4'b0000;
      #1;
      check("rstmid_grant", 32'(grant), 32'd0);
      check("rstmid_valid", 32'(grant_valid), 32'd0);
      check("rstmid_aw_done", 32'(aw_done), 32'd0);
      check("rstmid_idx", 32'(grant_idx), 32'd0);
      tick();
      reset = 1'b0;
      s_awvalid = 4'b1111;
      exp_q.push_back(0);
      tick();
      check_grant("postrst", owner);
      aw_phase();
      s_awvalid = 4'b0000;
      w_phase(1, 0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
